// File: rtl/eq_search_pkg.sv
// eq_search_pkg: shared FSM state type and default geometry for the equality search engine.
`default_nettype none
package eq_search_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/eq_cmp.sv
// eq_cmp: combinational WIDTH-bit exact equality comparator.
`default_nettype none
module eq_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/eq_search_ctrl.sv
// eq_search_ctrl: tagged-value table searched one entry per cycle through a single
// shared comparator; returns hit flag and lowest matching index over valid/ready.
`default_nettype none
module eq_search_ctrl
  import eq_search_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     clr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     search_valid,
  output logic                     search_ready,
  input  logic [WIDTH-1:0]         search_key,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     result_hit,
  output logic [$clog2(DEPTH)-1:0] result_idx,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [WIDTH-1:0]   key;
  logic [IDX_W-1:0]   ptr;
  logic               hit;
  logic [IDX_W-1:0]   idx;
  logic               eq;
  logic               match;
  logic               last;

  eq_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (mem[ptr]),
    .b  (key),
    .eq (eq)
  );

  // Invalid entries must never match even when stale data equals the key.
  assign match = vld[ptr] && eq;
  assign last  = (ptr == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (search_valid)          state_nxt = SCAN;
      SCAN:    if (match || last)         state_nxt = DONE;
      DONE:    if (result_ready)          state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vld   <= '0;
      key   <= '0;
      ptr   <= '0;
      hit   <= 1'b0;
      idx   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
        vld[wr_idx] <= 1'b1;
      end else if (clr_en) begin
        vld[wr_idx] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (search_valid) begin
            key <= search_key;
            ptr <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            hit <= 1'b1;
            idx <= ptr;
          end else if (last) begin
            hit <= 1'b0;
            idx <= '0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign search_ready = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result_hit   = hit;
  assign result_idx   = idx;

endmodule
`default_nettype wire

// File: tb/tb_eq_search_ctrl.sv
// tb_eq_search_ctrl: directed-vector bench for eq_search_ctrl with hand-computed expectations.
`default_nettype none
module tb_eq_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, clr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       search_valid, search_ready;
  logic [3:0] search_key;
  logic       result_valid, result_ready, result_hit;
  logic [2:0] result_idx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int lat;

  eq_search_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .clr_en       (clr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .search_valid (search_valid),
    .search_ready (search_ready),
    .search_key   (search_key),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_hit   (result_hit),
    .result_idx   (result_idx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [3:0] d);
    wr_en = 1'b1; wr_idx = 3'(i); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clr(input int i);
    clr_en = 1'b1; wr_idx = 3'(i);
    tick();
    clr_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic start(input string tag, input logic [3:0] k);
    check({tag, "_ready_before_accept"}, search_ready, 1);
    search_valid = 1'b1; search_key = k;
    tick();
    search_valid = 1'b0;
  endtask

  // Counts edges until result_valid; base is edges already spent since accept.
  task automatic wait_res(input int base, output int l);
    l = base;
    while (!result_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic finish_res();
    result_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clr_en = 1'b0; wr_idx = '0; wr_data = '0;
    search_valid = 1'b0; search_key = '0; result_ready = 1'b1;

    // 1. reset then idle, search on empty table
    do_reset(2);
    check("rst_ready", search_ready, 1);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", result_hit, 0);
    check("rst_idx", result_idx, 0);
    start("t1", 4'b0000);
    check("t1_busy_scan", busy, 1);
    wait_res(0, lat);
    check("t1_lat", lat, 8);
    check("t1_hit", result_hit, 0);
    check("t1_idx", result_idx, 0);
    check("t1_busy_done", busy, 1);
    finish_res();
    check("t1_back_idle", search_ready, 1);

    // 2. basic hit, lowest index wins
    wr(3, 4'b1001);
    wr(5, 4'b1001);
    start("t2", 4'b1001);
    wait_res(0, lat);
    check("t2_lat", lat, 4);
    check("t2_hit", result_hit, 1);
    check("t2_idx", result_idx, 3);
    finish_res();

    // 3. miss on invalidated entry
    for (int i = 0; i < 8; i++) wr(i, 4'b0011);
    clr(6);
    wr(6, 4'b1101);
    clr(6);
    start("t3", 4'b1101);
    wait_res(0, lat);
    check("t3_lat", lat, 8);
    check("t3_hit", result_hit, 0);
    check("t3_idx", result_idx, 0);
    finish_res();
    // simultaneous wr_en/clr_en: write wins, hit at last index
    wr_en = 1'b1; clr_en = 1'b1; wr_idx = 3'd7; wr_data = 4'b1101;
    tick();
    wr_en = 1'b0; clr_en = 1'b0;
    start("t3b", 4'b1101);
    wait_res(0, lat);
    check("t3b_lat", lat, 8);
    check("t3b_hit", result_hit, 1);
    check("t3b_idx", result_idx, 7);
    finish_res();

    // 4. backpressure and ignored second request
    wr(0, 4'b1111);
    result_ready = 1'b0;
    start("t4", 4'b1111);
    wait_res(0, lat);
    check("t4_lat", lat, 1);
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid", result_valid, 1);
      check("t4_hold_hit", result_hit, 1);
      check("t4_hold_idx", result_idx, 0);
      check("t4_hold_ready", search_ready, 0);
      search_valid = (c == 2); search_key = 4'b0000;
      tick();
    end
    search_valid = 1'b0;
    result_ready = 1'b1;
    check("t4_still_valid", result_valid, 1);
    tick();
    check("t4_idle_ready", search_ready, 1);
    check("t4_idle_valid", result_valid, 0);
    check("t4_idle_busy", busy, 0);
    tick();
    check("t4_no_phantom", result_valid, 0);

    // 5. write during scan, ahead of the pointer
    do_reset(1);
    start("t5", 4'b1011);
    repeat (2) tick();
    wr(4, 4'b1011);
    wait_res(3, lat);
    check("t5_lat", lat, 5);
    check("t5_hit", result_hit, 1);
    check("t5_idx", result_idx, 4);
    finish_res();
    // variant: write lands behind the pointer
    do_reset(1);
    start("t5b", 4'b1011);
    repeat (5) tick();
    wr(4, 4'b1011);
    wait_res(6, lat);
    check("t5b_lat", lat, 8);
    check("t5b_hit", result_hit, 0);
    check("t5b_idx", result_idx, 0);
    finish_res();

    // 6. reset mid-scan
    wr(2, 4'b0101);
    wr(7, 4'b0101);
    start("t6", 4'b0101);
    repeat (3) tick();
    do_reset(1);
    check("t6_ready", search_ready, 1);
    check("t6_valid", result_valid, 0);
    check("t6_busy", busy, 0);
    tick();
    check("t6_no_result", result_valid, 0);
    start("t6b", 4'b0101);
    wait_res(0, lat);
    check("t6b_lat", lat, 8);
    check("t6b_hit", result_hit, 0);
    check("t6b_idx", result_idx, 0);
    finish_res();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eq_search_ctrl.md
Name: eq_search_ctrl

Overview:
- Sequenced search engine around one shared WIDTH-bit equality comparator.
- Holds a DEPTH-entry table of tagged values and accepts search keys over a valid/ready handshake.
- Scans entries one per cycle through the single comparator and returns hit flag plus lowest matching index over a second valid/ready handshake.
- Serves as the lookup resource for downstream match/filter logic.

Parameters:
WIDTH, 4, bit width of table entries and search key
DEPTH, 8, number of table entries (power of two, >= 2)
IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wr_en  input  1  write wr_data into entry wr_idx and set its valid bit
clr_en  input  1  clear valid bit of entry wr_idx
wr_idx  input  IDX_W  table entry addressed by wr_en/clr_en
wr_data  input  WIDTH  value written on wr_en
search_valid  input  1  search request present
search_ready  output  1  controller can accept a search
search_key  input  WIDTH  key, sampled on accept
result_valid  output  1  result present
result_ready  input  1  consumer accepts result
result_hit  output  1  1 = a valid entry equal to key was found
result_idx  output  IDX_W  lowest matching index; 0 on miss
busy  output  1  high in SCAN or DONE

Behaviour:
- Reset (rst_n low at a rising edge): FSM to IDLE; all entry valid bits cleared; entry data and key register to 0; pointer to 0. Outputs after reset: search_ready=1, result_valid=0, result_hit=0, result_idx=0, busy=0.
- Reset mid-search or mid-result: same as above. No result is delivered for an abandoned search.
- Table write:
  - wr_en writes data and sets valid at the edge.
  - clr_en clears valid.
  - wr_en and clr_en together: wr_en wins.
  - Writes are legal in any state and take effect at the next edge.
  - A scan compares the table contents present in the cycle that entry is visited.
- FSM states IDLE, SCAN, DONE:
  - IDLE: search_ready=1. Accept on search_valid && search_ready: latch key, pointer=0, go to SCAN.
  - SCAN: search_ready=0. Comparator inputs are entry[ptr] and the latched key. A match is valid[ptr] && equal.
    - On a match: capture hit=1 and idx=ptr, go to DONE.
    - Else if ptr==DEPTH-1: capture hit=0 and idx=0, go to DONE.
    - Else: ptr++.
  - DONE: result_valid=1. result_hit and result_idx are held stable until result_valid && result_ready, then go to IDLE. With result_ready held high, DONE lasts exactly one cycle.
- Latency from the accept edge:
  - Hit at index i: result_valid rises after i+1 edges.
  - Miss: result_valid rises after DEPTH edges.
- The next accept is possible on the edge after result handoff. No back-to-back overlap.
- search_valid is ignored while search_ready=0. The key is not resampled.
- Exactly one comparator instance. Equality is exact over all WIDTH bits. Invalid entries never match, even if their data equals the key.
- Pointer never exceeds DEPTH-1. There is no wrap within a scan.

Decomposition:
- Package eq_search_pkg:
  - FSM state enum (IDLE, SCAN, DONE).
  - Default WIDTH/DEPTH localparams.
- Sub-module eq_cmp:
  - Purely combinational.
  - Inputs a[WIDTH], b[WIDTH]; output eq.
  - Instantiated once in eq_search_ctrl.
- Table storage, valid bits, pointer and FSM live in eq_search_ctrl.

Test Plan:
1. Reset then idle.
   - Stimulus: rst_n low 2 cycles, then high.
   - Required response: search_ready=1, result_valid=0, busy=0. A search for key 4'b0000 returns hit=0 and idx=0 after 8 edges, since all entries are invalid.
2. Basic hit and latency.
   - Stimulus: write entry3=4'b1001 and entry5=4'b1001, then search key 4'b1001 with result_ready=1.
   - Required response: hit=1, idx=3, result_valid after exactly 4 edges from accept.
3. Miss and invalid entries.
   - Stimulus: fill all 8 entries with 4'b0011, clr_en entry6, write entry6 data 4'b1101 then clr_en entry6 again, search 4'b1101.
   - Required response: hit=0, idx=0 after 8 edges.
4. Backpressure.
   - Stimulus: entry0=4'b1111, search 4'b1111, hold result_ready=0 for 5 cycles.
   - Required response: result_valid, hit=1 and idx=0 are stable for all 5 cycles. search_ready=0 throughout, and a second search_valid pulse with key 4'b0000 is ignored. IDLE follows one edge after result_ready=1.
5. Write during scan.
   - Stimulus: search 4'b1011 with table empty; during the cycle ptr==2, write entry4=4'b1011.
   - Required response: hit=1, idx=4.
   - Variant: same write issued while ptr==5 gives hit=0.
6. Reset mid-scan.
   - Stimulus: start a search, assert rst_n low while ptr==3.
   - Required response: next cycle is IDLE, result_valid=0, search_ready=1, all valid bits cleared (verified by a subsequent miss).
